// File: rtl/pipe_pkg.sv
// Shared types and ROB-age helpers for the elastic pipeline stages.
package pipe_pkg;

    localparam int PIPE_DATA_W   = 140;
    localparam int PIPE_ROB_ID_W = 7;

    typedef logic [PIPE_ROB_ID_W-1:0] rob_id_t;

    // Encoding doubles as the held-entry count driven on occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    function automatic rob_id_t rob_age(input rob_id_t id, input rob_id_t head);
        return id - head;
    endfunction

    function automatic logic rob_younger(input rob_id_t a, input rob_id_t b, input rob_id_t head);
        return rob_age(a, head) > rob_age(b, head);
    endfunction

endpackage

// File: rtl/rob_age_cmp.sv
// Decides whether one ROB id is strictly younger than the kill point, ages taken from rob_head.
module rob_age_cmp #(
    parameter int W = 7
) (
    input  logic [W-1:0] entry_id,
    input  logic [W-1:0] kill_id,
    input  logic [W-1:0] head,
    input  logic         kill_valid,
    output logic         dies
);
    logic [W-1:0] entry_age;
    logic [W-1:0] kill_age;

    // Modulo-2^W subtraction makes the age wrap with the ROB.
    assign entry_age = entry_id - head;
    assign kill_age  = kill_id - head;
    assign dies      = kill_valid & (entry_age > kill_age);
endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with flush and ROB-age kill.
// PIPE_SKID_STAGE_SKID_EN selects the two-entry skid buffer; otherwise a single main entry.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W   = PIPE_DATA_W,
    parameter int ROB_ID_W = PIPE_ROB_ID_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [ROB_ID_W-1:0] in_rob_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ROB_ID_W-1:0] out_rob_id,
    input  logic                flush,
    input  logic                kill_valid,
    input  logic [ROB_ID_W-1:0] kill_rob_id,
    input  logic [ROB_ID_W-1:0] rob_head,
    output logic [1:0]          occupancy
);
    // Handshake: a beat moves on a port only in a cycle where both valid and ready are high.
    stage_state_e        state_q, state_d, post_state;
    logic [ROB_ID_W-1:0] main_rob_q, main_rob_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                main_die, in_die, post_main_die;
    logic                in_fire, out_fire;

    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_data_q;
    assign out_rob_id = main_rob_q;
    assign occupancy  = state_q;
    assign out_fire   = out_valid & out_ready;
    assign in_fire    = in_valid & in_ready;

    rob_age_cmp #(.W(ROB_ID_W)) u_cmp_main (
        .entry_id(main_rob_q), .kill_id(kill_rob_id), .head(rob_head),
        .kill_valid(kill_valid), .dies(main_die)
    );
    rob_age_cmp #(.W(ROB_ID_W)) u_cmp_in (
        .entry_id(in_rob_id), .kill_id(kill_rob_id), .head(rob_head),
        .kill_valid(kill_valid), .dies(in_die)
    );

`ifdef PIPE_SKID_STAGE_SKID_EN
    logic [ROB_ID_W-1:0] skid_rob_q, skid_rob_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_die, post_skid_die;
    logic                in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    rob_age_cmp #(.W(ROB_ID_W)) u_cmp_skid (
        .entry_id(skid_rob_q), .kill_id(kill_rob_id), .head(rob_head),
        .kill_valid(kill_valid), .dies(skid_die)
    );

    always_comb begin
        post_state    = state_q;
        main_rob_d    = main_rob_q;
        main_data_d   = main_data_q;
        skid_rob_d    = skid_rob_q;
        skid_data_d   = skid_data_q;
        post_main_die = main_die;
        post_skid_die = skid_die;
        unique case (state_q)
            ST_EMPTY: if (in_fire) begin
                post_state    = ST_ONE;
                main_rob_d    = in_rob_id;
                main_data_d   = in_data;
                post_main_die = in_die;
            end
            ST_ONE: if (in_fire && out_fire) begin
                main_rob_d    = in_rob_id;
                main_data_d   = in_data;
                post_main_die = in_die;
            end else if (in_fire) begin
                post_state    = ST_TWO;
                skid_rob_d    = in_rob_id;
                skid_data_d   = in_data;
                post_skid_die = in_die;
            end else if (out_fire) begin
                post_state    = ST_EMPTY;
            end
            ST_TWO: if (out_fire) begin
                post_state    = ST_ONE;
                main_rob_d    = skid_rob_q;
                main_data_d   = skid_data_q;
                post_main_die = skid_die;
            end
            default: post_state = ST_EMPTY;
        endcase

        // Skid is always younger than main, so a dead main takes the skid with it.
        state_d = post_state;
        if (flush)
            state_d = ST_EMPTY;
        else if (post_state != ST_EMPTY && post_main_die)
            state_d = ST_EMPTY;
        else if (post_state == ST_TWO && post_skid_die)
            state_d = ST_ONE;
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_rob_q  <= '0;
            main_data_q <= '0;
            skid_rob_q  <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_rob_q  <= main_rob_d;
            main_data_q <= main_data_d;
            skid_rob_q  <= skid_rob_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign in_ready = out_ready | ~out_valid;

    always_comb begin
        post_state    = state_q;
        main_rob_d    = main_rob_q;
        main_data_d   = main_data_q;
        post_main_die = main_die;
        if (in_fire) begin
            post_state    = ST_ONE;
            main_rob_d    = in_rob_id;
            main_data_d   = in_data;
            post_main_die = in_die;
        end else if (out_fire) begin
            post_state    = ST_EMPTY;
        end

        state_d = post_state;
        if (flush || (post_state != ST_EMPTY && post_main_die))
            state_d = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_rob_q  <= '0;
            main_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_rob_q  <= main_rob_d;
            main_data_q <= main_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage against a queue-based reference model.
module tb_pipe_skid_stage;
    localparam int DATA_W   = 140;
    localparam int ROB_ID_W = 7;
`ifdef PIPE_SKID_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data = '0;
    logic [ROB_ID_W-1:0] in_rob_id = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic [ROB_ID_W-1:0] out_rob_id;
    logic                flush = 1'b0;
    logic                kill_valid = 1'b0;
    logic [ROB_ID_W-1:0] kill_rob_id = '0;
    logic [ROB_ID_W-1:0] rob_head = '0;
    logic [1:0]          occupancy;

    pipe_skid_stage #(.DATA_W(DATA_W), .ROB_ID_W(ROB_ID_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rob_id(in_rob_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rob_id(out_rob_id),
        .flush(flush), .kill_valid(kill_valid), .kill_rob_id(kill_rob_id),
        .rob_head(rob_head), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected held beats, oldest first.
    logic [ROB_ID_W-1:0] exp_id_q[$];
    logic [DATA_W-1:0]   exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  last_acc = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int age(input logic [ROB_ID_W-1:0] id, input logic [ROB_ID_W-1:0] head);
        return (int'(id) + (1 << ROB_ID_W) - int'(head)) % (1 << ROB_ID_W);
    endfunction

    // Check the DUT against the model, then advance the model by one clock edge.
    task automatic cycle();
        logic exp_ready;
        bit   ofire, ifire;
        logic [ROB_ID_W-1:0] keep_id[$];
        logic [DATA_W-1:0]   keep_d[$];
        #1;
        if (reset) begin
            exp_id_q.delete();
            exp_q.delete();
            last_acc = 0;
        end else begin
            if (CAP == 2) exp_ready = (exp_id_q.size() < 2);
            else          exp_ready = out_ready || (exp_id_q.size() == 0);
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, exp_id_q.size() > 0);
            check("occupancy", occupancy, exp_id_q.size());
            if (exp_id_q.size() > 0) begin
                check("out_rob_id", out_rob_id, exp_id_q[0]);
                check("out_data", out_data, exp_q[0]);
            end
            ofire = (exp_id_q.size() > 0) && out_ready;
            ifire = in_valid && exp_ready;
            if (ofire) begin
                void'(exp_id_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (ifire) begin
                exp_id_q.push_back(in_rob_id);
                exp_q.push_back(in_data);
            end
            if (flush) begin
                exp_id_q.delete();
                exp_q.delete();
            end else if (kill_valid) begin
                for (int i = 0; i < exp_id_q.size(); i++) begin
                    if (age(exp_id_q[i], rob_head) <= age(kill_rob_id, rob_head)) begin
                        keep_id.push_back(exp_id_q[i]);
                        keep_d.push_back(exp_q[i]);
                    end
                end
                exp_id_q = keep_id;
                exp_q    = keep_d;
            end
            last_acc = ifire;
        end
        @(posedge clk);
    endtask

    task automatic drive(input logic iv, input logic [ROB_ID_W-1:0] id, input logic ordy,
                         input logic fl, input logic kv, input logic [ROB_ID_W-1:0] kid,
                         input logic [ROB_ID_W-1:0] hd);
        logic [159:0] r;
        @(negedge clk);
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        in_valid    = iv;
        in_rob_id   = id;
        in_data     = r[DATA_W-1:0];
        out_ready   = ordy;
        flush       = fl;
        kill_valid  = kv;
        kill_rob_id = kid;
        rob_head    = hd;
        cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle();
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_rob_id", out_rob_id, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_occupancy", occupancy, 2'd0);
    endtask

    initial begin
        int k;
        logic [ROB_ID_W-1:0] bp_ids[3];
        bp_ids = '{7'd3, 7'd4, 7'd5};

        do_reset();
        check_reset_outputs();

        // Streaming, ids 5..14
        for (int i = 5; i <= 14; i++) drive(1, ROB_ID_W'(i), 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 0);

        // Backpressure with the upstream holding a beat until it is taken
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(k < 3, (k < 3) ? bp_ids[k] : 7'd0, c >= 4, 0, 0, 0, 0);
            if (last_acc) k++;
        end
        check("bp_all_accepted", k, 3);

        // Selective kill across the ROB wrap
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(1, 126, 0, 0, 0, 0, 120);
        drive(1, 1, 0, 0, 0, 0, 120);
        drive(0, 0, 0, 0, 1, 127, 120);
        drive(0, 0, 0, 0, 0, 0, 120);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 0);

        // Equal-age kill survives, concurrent younger beat dropped
        drive(1, 40, 0, 0, 0, 0, 30);
        drive(1, 41, 0, 0, 1, 40, 30);
        drive(0, 0, 0, 0, 0, 0, 30);
        for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, 0, 0, 0);

        // Flush while full with a beat arriving
        drive(1, 10, 0, 0, 0, 0, 0);
        drive(1, 11, 0, 0, 0, 0, 0);
        drive(1, 12, 0, 1, 0, 0, 0);
        drive(1, 13, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);

        // Reset mid-stream while full
        drive(1, 20, 0, 0, 0, 0, 0);
        drive(1, 21, 0, 0, 0, 0, 0);
        do_reset();
        check_reset_outputs();

        // Random traffic with flushes and kills
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, ROB_ID_W'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                  ROB_ID_W'($urandom), ROB_ID_W'($urandom_range(0, 3) * 32));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic elastic pipeline-stage register that replaces the hand-written per-stage latches between decode, execute and later stages.
- Carries an opaque payload plus a ROB id, using a valid/ready handshake.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Supports a global flush and a selective ROB-age kill for branch mispredicts.

Parameters:
- DATA_W, 140, payload width in bits (instr type, pc, opcode, functs, operands, immediate).
- ROB_ID_W, 7, ROB id width; ids compare modulo 2^ROB_ID_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  DATA_W  upstream payload
- in_rob_id  in  ROB_ID_W  ROB id of the upstream beat
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload of the oldest held entry
- out_rob_id  out  ROB_ID_W  ROB id of the oldest held entry
- flush  in  1  kill everything, including the incoming beat
- kill_valid  in  1  selective kill request
- kill_rob_id  in  ROB_ID_W  id of the mispredicted instruction; it survives, younger entries die
- rob_head  in  ROB_ID_W  current ROB head, used as the age origin
- occupancy  out  2  number of held entries (0..2)

Behaviour:
- Storage: main entry (drives out_*) and skid entry; each is {valid, rob_id, data}. The skid entry is always younger than main.
- States:
  - EMPTY: no entries held.
  - ONE: main valid.
  - TWO: main and skid valid.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = main.valid.
  - in_ready = !skid.valid, registered; no combinational path from out_ready.
- Transitions when flush=0 and kill_valid=0:
  - EMPTY: in_fire -> ONE.
  - ONE: in_fire & !out_fire -> TWO (beat goes to skid). in_fire & out_fire -> ONE (beat replaces main). out_fire only -> EMPTY.
  - TWO: out_fire -> ONE (skid moves to main, skid cleared). in_valid is ignored in TWO because in_ready=0.
- Age rule: age(x) = (x - rob_head) mod 2^ROB_ID_W. An entry dies when kill_valid=1 and age(entry.rob_id) > age(kill_rob_id). Equal age survives.
- Kill timing:
  - Kill is evaluated on the state held at the clock edge, after applying that cycle's out_fire and in_fire.
  - An incoming beat accepted in the same cycle is also tested and dropped if it is younger.
  - Because entries are ordered, a dead main implies a dead skid.
  - If only skid dies, the state falls to ONE.
- flush=1:
  - All valids clear next cycle.
  - A beat accepted that cycle is discarded.
  - out_fire in a flush cycle still counts as consumed downstream.
- Priority: reset > flush > kill > normal operation.
- Data registers load only on capture. out_data/out_rob_id hold their last value while out_valid=0 and must be treated as don't-care.
- Reset values: all valids 0, in_ready 1, out_valid 0, out_data 0, out_rob_id 0, occupancy 0. Reset during TWO drops both entries with no output beat.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 beat/cycle sustained.
- Occupancy equals the number of set valids. It never exceeds 2 and never underflows.

Optional Feature:
- PIPE_SKID_STAGE_SKID_EN, defined:
  - Two-entry skid behaviour exactly as above.
  - in_ready is registered.
- PIPE_SKID_STAGE_SKID_EN, undefined:
  - Single main entry only; the TWO state is unreachable.
  - in_ready = out_ready | !out_valid, combinational.
  - occupancy is at most 1.
  - Flush and kill rules are unchanged and apply to main and the incoming beat.

Decomposition:
- Shared package pipe_pkg:
  - rob_id_t typedef.
  - Default DATA_W / ROB_ID_W constants.
  - rob_age function: (id - head) mod 2^W.
  - rob_younger function: strict compare of ages.
- Sub-module rob_age_cmp (pure combinational), instantiated three times: main, skid, incoming.
- Stages pack their fields into in_data outside this block.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 for 10 beats, ids 5..14 -> out ids 5..14 on consecutive cycles; in_ready stays 1; occupancy 1.
- Backpressure: out_ready=0, push ids 3,4 -> occupancy 2 and in_ready=0. Id 5 is held upstream. Raise out_ready -> outputs 3,4,5 in order with no loss.
- Selective kill: rob_head=120, held ids 126 and 1, kill_rob_id=127 -> id 1 (age 9) is killed, id 126 (age 6) survives. occupancy 1, out_rob_id=126.
- Kill equal id: held 40, kill_rob_id=40, rob_head=30 -> entry survives. Concurrent incoming id 41 is dropped.
- Flush in TWO state with in_valid=1 -> next cycle out_valid=0, occupancy 0, in_ready=1.
- Reset asserted mid-stream with occupancy 2 -> next cycle out_valid=0, out_data=0, in_ready=1. Repeat with the macro undefined: in_ready follows out_ready combinationally.
